// File: rtl/mac_result_requant.sv
// mac_result_requant: reassembles the MAC's 32-bit accumulator from an
// MSB-first byte stream, applies ReLU, right-shift requantisation and unsigned
// saturation, then buffers the OUT_W-bit activations in a first-word-fall-through
// FIFO with a valid/ready output handshake.
// Optional build macro ROUND_EN: round-half-up before the shift instead of
// truncation.
module mac_result_requant #(
    parameter int SHIFT      = 8,
    parameter int OUT_W      = 7,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic                            in_first,
    input  logic [7:0]                      in_byte,
    output logic                            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_W-1:0]                out_data,
    output logic                            out_sat,
    output logic                            frame_err,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [32:0]      MAX_Q      = (33'd1 << OUT_W) - 33'd1;
    localparam logic [32:0]      ROUND_BIAS = (33'd1 << SHIFT) >> 1;
    localparam logic [LVL_W-1:0] DEPTH_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W:0]   DEPTH_OCC  = (LVL_W + 1)'(FIFO_DEPTH);

    // Byte assembly state: only bytes 0..2 need storing, byte 3 goes straight to stage 2.
    logic [1:0]  cnt;
    logic [23:0] acc;
    logic [31:0] s2_word;
    logic        s2_valid;

    logic        accept;
    logic [1:0]  byte_idx;
    logic        word_done;
    logic        framing_bad;

    // FIFO state; each entry carries {sat, data}.
    logic [OUT_W:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               push;
    logic               pop;

    logic [32:0]        biased;
    logic [32:0]        q;
    logic [OUT_W-1:0]   s2_data;
    logic               s2_sat;

    assign accept = in_valid & in_ready;

    // Decode which byte of the word the current input represents.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        byte_idx    = cnt;
        framing_bad = 1'b0;
        if (in_first) begin
            byte_idx    = 2'd0;
            framing_bad = (cnt != 2'd0);
        end else begin
            framing_bad = (cnt == 2'd0);
        end
        word_done = (byte_idx == 2'd3);
    end

    // Shift accepted bytes into the assembly register and track the byte count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            cnt       <= 2'd0;
            acc       <= '0;
            frame_err <= 1'b0;
        end else if (accept) begin
            acc <= {acc[15:0], in_byte};
            cnt <= byte_idx + 2'd1;
            if (framing_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

    // Stage 2 holds a complete word until it is pushed into the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_word  <= '0;
            s2_valid <= 1'b0;
        end else if (accept && word_done) begin
            s2_word  <= {acc, in_byte};
            s2_valid <= 1'b1;
        end else if (push) begin
            s2_valid <= 1'b0;
        end
    end

    // ReLU, optional rounding, shift and saturation on the stage-2 word.
    always_comb begin
        biased  = {1'b0, s2_word};
`ifdef ROUND_EN
        biased  = biased + ROUND_BIAS;
`endif
        q       = biased >> SHIFT;
        s2_data = '0;
        s2_sat  = 1'b0;
        if (s2_word[31]) begin
            s2_data = '0;
            s2_sat  = 1'b0;
        end else if (q > MAX_Q) begin
            s2_data = MAX_Q[OUT_W-1:0];
            s2_sat  = 1'b1;
        end else begin
            s2_data = q[OUT_W-1:0];
        end
    end

    assign push      = s2_valid && (level != DEPTH_LVL);
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; level and pointers alone decide what is valid.
        if (push) begin
            mem[wr_ptr] <= {s2_sat, s2_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign out_data   = out_valid ? mem[rd_ptr][OUT_W-1:0] : '0;
    assign out_sat    = out_valid ? mem[rd_ptr][OUT_W] : 1'b0;
    assign fifo_level = level;

    // Accept input only while FIFO plus stage 2 still has room for one more word.
    assign in_ready = ({1'b0, level} + {{LVL_W{1'b0}}, s2_valid}) < DEPTH_OCC;

endmodule

// File: tb/tb_mac_result_requant.sv
// Self-checking bench for mac_result_requant: directed scenarios plus random
// words, compared against an arithmetic reference model of the requantiser.
module tb_mac_result_requant;

    localparam int SHIFT      = 8;
    localparam int OUT_W      = 7;
    localparam int FIFO_DEPTH = 2;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_first;
    logic [7:0]         in_byte;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_sat;
    logic               frame_err;
    logic [LVL_W-1:0]   fifo_level;

    int checks = 0;
    int errors = 0;

    logic [OUT_W:0] exp_q[$];
    logic [OUT_W:0] got_q[$];

    mac_result_requant #(
        .SHIFT      (SHIFT),
        .OUT_W      (OUT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_first   (in_first),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .frame_err  (frame_err),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every completed output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back({out_sat, out_data});
        end
    end

    // Reference: {sat, data} from the signed accumulator value.
    function automatic logic [OUT_W:0] model(input logic [31:0] w);
        longint v;
        longint max_v;
        max_v = (longint'(1) << OUT_W) - 1;
        if ($signed(w) < 0) return '0;
        v = longint'(w);
`ifdef ROUND_EN
        if (SHIFT > 0) v = v + (longint'(1) << SHIFT) / 2;
`endif
        v = v / (longint'(1) << SHIFT);
        if (v > max_v) return {1'b1, OUT_W'(max_v)};
        return {1'b0, OUT_W'(v)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted (bounded).
    task automatic send_byte(input logic first, input logic [7:0] b);
        int k;
        in_valid = 1'b1;
        in_first = first;
        in_byte  = b;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 200) begin
            check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(1'b1, w[31:24]);
        send_byte(1'b0, w[23:16]);
        send_byte(1'b0, w[15:8]);
        send_byte(1'b0, w[7:0]);
    endtask

    // Wait for all expected results, then compare in order; leaves inputs aligned.
    task automatic drain(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_item%0d", tag, i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        end
        exp_q.delete();
        got_q.delete();
        align();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        logic [OUT_W:0] e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        align();
        align();
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {25'd0, out_data}, 32'd0);
        check("rst_out_sat", {31'd0, out_sat}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_fifo_level", {30'd0, fifo_level}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        align();

        // Basic word and output latency
        out_ready = 1'b1;
        w = 32'h0000_1280;
        e = model(w);
        exp_q.push_back(e);
        send_word(w);
        @(negedge clk);
        check("lat_valid_n", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_valid_n1", {31'd0, out_valid}, 32'd1);
        check("lat_data", {25'd0, out_data}, {25'd0, e[OUT_W-1:0]});
        drain("basic");

        // ReLU, saturation and the saturation boundary
        w = 32'hFFFF_FF00; exp_q.push_back(model(w)); send_word(w);
        w = 32'h0001_0000; exp_q.push_back(model(w)); send_word(w);
        w = 32'h0000_7F80; exp_q.push_back(model(w)); send_word(w);
        w = 32'h0000_7FFF; exp_q.push_back(model(w)); send_word(w);
        w = 32'h7FFF_FFFF; exp_q.push_back(model(w)); send_word(w);
        drain("edges");

        // Random words across negative, in-range and saturating values
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0:       w = $urandom;
                1:       w = 32'($urandom_range(0, 40000));
                default: w = 32'h8000_0000 | 32'($urandom);
            endcase
            exp_q.push_back(model(w));
            send_word(w);
        end
        drain("rand");

        // Backpressure: two words fill the FIFO, third waits
        out_ready = 1'b0;
        w = 32'h0000_0A00; exp_q.push_back(model(w)); send_word(w);
        e = model(w);
        w = 32'h0000_0B40; exp_q.push_back(model(w)); send_word(w);
        @(negedge clk);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("bp_level_full", {30'd0, fifo_level}, 32'd2);
        check("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
        check("bp_head_data", {25'd0, out_data}, {25'd0, e[OUT_W-1:0]});
        align();
        out_ready = 1'b1;
        w = 32'h0000_0C80; exp_q.push_back(model(w)); send_word(w);
        drain("bp");

        // Framing: partial word then a restart with in_first
        send_byte(1'b1, 8'h00);
        send_byte(1'b0, 8'h00);
        w = 32'h0000_0100; exp_q.push_back(model(w)); send_word(w);
        @(negedge clk);
        check("frame_restart_err", {31'd0, frame_err}, 32'd1);
        drain("frame_restart");

        // Framing: missing in_first, byte still taken as byte 0
        do_reset();
        send_byte(1'b0, 8'h00);
        @(negedge clk);
        check("frame_nofirst_err", {31'd0, frame_err}, 32'd1);
        align();
        send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'h03);
        send_byte(1'b0, 8'h00);
        exp_q.push_back(model(32'h0000_0300));
        drain("frame_nofirst");

        // Reset with a partial word and a buffered entry
        out_ready = 1'b0;
        send_word(32'h0000_0500);
        send_byte(1'b1, 8'h00);
        send_byte(1'b0, 8'h00);
        @(negedge clk);
        check("pre_rst_level", {30'd0, fifo_level}, 32'd1);
        align();
        do_reset();
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_level", {30'd0, fifo_level}, 32'd0);
        check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        align();
        got_q.delete();
        out_ready = 1'b1;
        w = 32'h0000_1E00; exp_q.push_back(model(w)); send_word(w);
        drain("post_rst");
        check("post_rst_frame_err", {31'd0, frame_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
